// File: rtl/bit_scan16.sv
// bit_scan16 -- serialises a 16-bit request mask into a stream of set-bit
// indices, lowest index first, one index per output transfer.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      synchronous, active-high; returns to IDLE and drops any mask
//   in_valid   producer offers in_mask
//   in_mask    16-bit mask to decode (sampled only on a load edge)
//   in_ready   high in IDLE; a mask can be loaded
//   out_valid  high in EMIT; out_idx/out_last/out_none/out_seq are valid
//   out_ready  consumer accepts the current index
//   out_idx    lowest pending set-bit index
//   out_last   this transfer is the final one for the loaded mask
//   out_none   the loaded mask was all zeros (one dummy transfer, idx 0)
//   out_seq    ordinal of the current transfer within the mask, from 0
//   dbg_state  current FSM state (0 = IDLE, 1 = EMIT)
//
// Handshake: a beat moves on a rising edge where valid and ready are both
// high. valid never depends on ready, and once out_valid is raised the
// output fields stay frozen until the beat is taken. in_ready and out_valid
// are mutually exclusive, so a new mask can only be loaded from IDLE and at
// least one IDLE cycle separates consecutive masks.

module bit_scan16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_mask,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic        out_none,
    output logic [3:0]  out_seq,
    output logic [0:0]  dbg_state
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]  state;
    logic [15:0] pend;
    logic [3:0]  seq;
    logic        none_q;

    logic [3:0]  lsb_idx;
    logic        last_c;

    // Lowest set bit of pend. Scanning downward lets the lowest match win;
    // an empty pend yields 0, which is also the required zero-mask index.
    always_comb begin
        lsb_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pend[i]) begin
                lsb_idx = 4'(i);
            end
        end
    end

    // At most one bit set: clearing the lowest set bit leaves nothing.
    assign last_c = ~|(pend & (pend - 16'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pend   <= 16'd0;
            seq    <= 4'd0;
            none_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state  <= EMIT;
                        pend   <= in_mask;
                        seq    <= 4'd0;
                        none_q <= (in_mask == 16'd0);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (last_c) begin
                            // Clear everything so the idle outputs read zero.
                            state  <= IDLE;
                            pend   <= 16'd0;
                            seq    <= 4'd0;
                            none_q <= 1'b0;
                        end else begin
                            pend <= pend & ~(16'd1 << lsb_idx);
                            seq  <= seq + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign out_idx   = lsb_idx;
    assign out_last  = out_valid & last_c;
    assign out_none  = out_valid & none_q;
    assign out_seq   = seq;
    assign dbg_state = state;

endmodule

// File: tb/tb_bit_scan16.sv
// Testbench for bit_scan16: directed masks, expected transfers pushed into a
// queue by the driver and popped/compared by an independent monitor.

module tb_bit_scan16;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_mask;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        out_none;
    logic [3:0]  out_seq;
    logic [0:0]  dbg_state;

    // Expected transfer: {idx[3:0], seq[3:0], last, none}
    logic [9:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    bit_scan16 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_mask   (in_mask),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none),
        .out_seq   (out_seq),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared check ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] ent(input int idx, input int seq, input bit last, input bit none);
        return {4'(idx), 4'(seq), last, none};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    // Inputs only change #1 after a rising edge, so what is seen on the
    // falling edge is what the next rising edge acts on.
    logic       stalled;
    logic [9:0] held;

    initial stalled = 1'b0;

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (stalled) begin
                check("stall_hold", {6'd0, out_idx, out_seq, out_last, out_none}, {6'd0, held});
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", {6'd0, out_idx, out_seq, out_last, out_none}, 16'hFFFF);
                end else begin
                    check("xfer", {6'd0, out_idx, out_seq, out_last, out_none}, {6'd0, exp_q.pop_front()});
                end
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = {out_idx, out_seq, out_last, out_none};
            end
        end else begin
            stalled = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] m);
        int budget;
        budget = 0;
        while (!in_ready && budget < 100) begin
            step();
            budget++;
        end
        in_valid = 1'b1;
        in_mask  = m;
        step();
        in_valid = 1'b0;
        check("load_latency_valid", {15'd0, out_valid}, 16'd1);
        check("load_ready_low", {15'd0, in_ready}, 16'd0);
    endtask

    task automatic wait_idle(input bit rand_ready);
        int budget;
        budget = 0;
        while (!(in_ready && exp_q.size() == 0) && budget < 300) begin
            if (rand_ready) begin
                out_ready = 1'($urandom_range(0, 1));
                in_mask   = 16'($urandom);
            end
            step();
            budget++;
        end
        out_ready = 1'b1;
        check("drain_timeout", 16'(budget >= 300), 16'd0);
        check("idle_ready", {15'd0, in_ready}, 16'd1);
        check("queue_empty", 16'(exp_q.size()), 16'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mask   = 16'h0000;
        out_ready = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_in_ready",  {15'd0, in_ready},  16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_out_idx",   {12'd0, out_idx},   16'd0);
        check("rst_out_last",  {15'd0, out_last},  16'd0);
        check("rst_out_none",  {15'd0, out_none},  16'd0);
        check("rst_out_seq",   {12'd0, out_seq},   16'd0);
        reset = 1'b0;

        // IDLE with in_valid low: mask wiggles must not start anything
        in_mask = 16'h1234;
        step();
        in_mask = 16'hFFFF;
        step();
        check("idle_hold_valid", {15'd0, out_valid}, 16'd0);
        check("idle_hold_ready", {15'd0, in_ready},  16'd1);

        // 16'h8421: indices 0,5,10,15
        exp_q.push_back(ent(0, 0, 0, 0));
        exp_q.push_back(ent(5, 1, 0, 0));
        exp_q.push_back(ent(10, 2, 0, 0));
        exp_q.push_back(ent(15, 3, 1, 0));
        load(16'h8421);
        wait_idle(1'b0);

        // Zero mask: single transfer flagged none
        exp_q.push_back(ent(0, 0, 1, 1));
        load(16'h0000);
        check("zero_none", {15'd0, out_none}, 16'd1);
        wait_idle(1'b0);

        // Full mask with random back-pressure and in_mask noise while busy
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(ent(i, i, i == 15, 0));
        end
        load(16'hFFFF);
        wait_idle(1'b1);

        // 16'h0100, new mask offered during its final transfer
        exp_q.push_back(ent(8, 0, 1, 0));
        load(16'h0100);
        check("single_last", {15'd0, out_last}, 16'd1);
        in_valid = 1'b1;
        in_mask  = 16'h0003;
        exp_q.push_back(ent(0, 0, 0, 0));
        exp_q.push_back(ent(1, 1, 1, 0));
        step();
        check("gap_out_valid", {15'd0, out_valid}, 16'd0);
        check("gap_in_ready",  {15'd0, in_ready},  16'd1);
        step();
        in_valid = 1'b0;
        check("reload_valid", {15'd0, out_valid}, 16'd1);
        wait_idle(1'b0);

        // 16'h00F0, reset after the first transfer
        exp_q.push_back(ent(4, 0, 0, 0));
        load(16'h00F0);
        step();
        check("pre_rst_idx", {12'd0, out_idx}, 16'd5);
        reset     = 1'b1;
        out_ready = 1'b0;
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        check("mid_rst_ready", {15'd0, in_ready},  16'd1);
        check("mid_rst_seq",   {12'd0, out_seq},   16'd0);
        check("mid_rst_idx",   {12'd0, out_idx},   16'd0);
        repeat (3) step();
        check("post_rst_quiet", {15'd0, out_valid}, 16'd0);
        exp_q.push_back(ent(1, 0, 1, 0));
        load(16'h0002);
        wait_idle(1'b0);

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
